// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: texel word, dispatcher states and
// the frame marker words used by the assembler and the dispatcher.
package gpu_pkg;

  localparam int TEXEL_W = 168;

  typedef logic [TEXEL_W-1:0] texel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } disp_state_t;

  // Frame marker words exchanged with the texel assembler.
  localparam texel_t FRAME_START = texel_t'(0);
  localparam texel_t FRAME_END   = texel_t'(1);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping around modulo N. Grant is one-hot or zero.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             gnt_valid
);

  // Requests rotated so that bit 0 corresponds to the unit at ptr.
  logic [N-1:0]   rot_req;
  // Double-width one-hot used to fold a rotated position back into range.
  logic [2*N-1:0] hot;

  // Rotate requests down by ptr using a doubled copy of the vector.
  always_comb begin
    rot_req = N'({req, req} >> ptr);
  end

  // Priority-pick the first rotated request and map it back to a unit index.
  always_comb begin
    grant     = '0;
    gnt_valid = 1'b0;
    hot       = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid && rot_req[k]) begin
        gnt_valid = 1'b1;
        hot       = ((2*N)'(1) << ptr) << k;
        grant     = hot[N-1:0] | hot[2*N-1:N];
      end
    end
  end

endmodule

// File: rtl/texel_dispatcher.sv
// Texel dispatcher: hands each assembled triangle to an idle rasterizer
// chosen round-robin, counts triangles per frame and drains all units
// before acknowledging a frame end.
module texel_dispatcher #(
  parameter int NUM_RASTER = 4,
  parameter int TEXEL_W    = 168,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [TEXEL_W-1:0]    texel_buffer,
  input  logic                  texel_ready,
  output logic                  texel_read,
  input  logic [NUM_RASTER-1:0] raster_busy,
  output logic [NUM_RASTER-1:0] raster_start,
  output logic [TEXEL_W-1:0]    raster_tri,
  input  logic                  frame_end_req,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      tri_count
);

  import gpu_pkg::*;

  localparam int PTR_W = (NUM_RASTER > 1) ? $clog2(NUM_RASTER) : 1;

  disp_state_t           state_reg, state_next;
  logic [PTR_W-1:0]      rr_ptr_reg;
  logic [PTR_W-1:0]      rr_ptr_next;
  logic [NUM_RASTER-1:0] pending_reg;
  logic [NUM_RASTER-1:0] grant_reg;
  logic                  end_pend_reg;
  logic                  texel_read_reg;
  logic [NUM_RASTER-1:0] raster_start_reg;
  logic [TEXEL_W-1:0]    raster_tri_reg;
  logic                  frame_done_reg;
  logic [CNT_W-1:0]      tri_count_reg;

  logic [NUM_RASTER-1:0] avail;
  logic [NUM_RASTER-1:0] arb_grant;
  logic                  arb_valid;
  logic                  issue_go;
  logic                  drain_done;
  logic [PTR_W-1:0]      grant_idx;

  // A unit is available when it is not busy and was not started last cycle.
  generate
    for (genvar gi = 0; gi < NUM_RASTER; gi++) begin : g_avail
      assign avail[gi] = ~raster_busy[gi] & ~pending_reg[gi];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_RASTER),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (avail),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .gnt_valid (arb_valid)
  );

  // Encode the latched grant and compute the pointer just past it.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_RASTER; i++) begin
      if (grant_reg[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
    if (grant_idx == PTR_W'(NUM_RASTER - 1)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = grant_idx + PTR_W'(1);
    end
  end

  // Next-state logic; issue_go and drain_done mark the transition edges.
  always_comb begin
    state_next = state_reg;
    issue_go   = 1'b0;
    drain_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (texel_ready && arb_valid && !end_pend_reg) begin
          state_next = ISSUE;
          issue_go   = 1'b1;
        end else if (end_pend_reg && !texel_ready) begin
          state_next = DRAIN;
        end
      end
      ISSUE: begin
        state_next = IDLE;
      end
      DRAIN: begin
        if ((raster_busy == '0) && (pending_reg == '0)) begin
          state_next = IDLE;
          drain_done = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Registered handshake and start pulses, valid only during ISSUE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      texel_read_reg   <= 1'b0;
      raster_start_reg <= '0;
      frame_done_reg   <= 1'b0;
    end else begin
      texel_read_reg   <= issue_go;
      raster_start_reg <= issue_go ? arb_grant : '0;
      frame_done_reg   <= drain_done;
    end
  end

  // Capture the triangle and the chosen unit when an issue begins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      raster_tri_reg <= '1;
      grant_reg      <= '0;
    end else if (issue_go) begin
      raster_tri_reg <= texel_buffer;
      grant_reg      <= arb_grant;
    end
  end

  // Leaving ISSUE: mark the unit pending, advance the pointer, count it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_reg   <= '0;
      rr_ptr_reg    <= '0;
      tri_count_reg <= '0;
    end else begin
      pending_reg <= (state_reg == ISSUE) ? grant_reg : '0;
      if (state_reg == ISSUE) begin
        rr_ptr_reg    <= rr_ptr_next;
        tri_count_reg <= tri_count_reg + CNT_W'(1);
      end else if (drain_done) begin
        tri_count_reg <= '0;
      end
    end
  end

  // Frame-end request latch; requests arriving while draining are ignored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      end_pend_reg <= 1'b0;
    end else if (drain_done) begin
      end_pend_reg <= 1'b0;
    end else if (frame_end_req && (state_reg != DRAIN)) begin
      end_pend_reg <= 1'b1;
    end
  end

  assign texel_read   = texel_read_reg;
  assign raster_start = raster_start_reg;
  assign raster_tri   = raster_tri_reg;
  assign frame_done   = frame_done_reg;
  assign tri_count    = tri_count_reg;

endmodule

// File: tb/tb_texel_dispatcher.sv
// Bench for texel_dispatcher: table of single-triangle issues plus
// hand-written reset, stall and frame-end sequences, with a scoreboard
// of expected start/triangle pairs checked on every start pulse.
module tb_texel_dispatcher;

  localparam int NR       = 4;
  localparam int TW       = 168;
  localparam int CW       = 16;
  localparam int BUSY_DUR = 2;

  typedef logic [TW-1:0] w_t;

  typedef struct {
    logic [NR-1:0] frc;
    w_t            data;
    logic [NR-1:0] exp_start;
  } vec_t;

  typedef struct {
    logic [NR-1:0] start;
    w_t            tri_w;
  } sb_t;

  logic          clk;
  logic          n_rst;
  w_t            texel_buffer;
  logic          texel_ready;
  logic          texel_read;
  logic [NR-1:0] raster_busy;
  logic [NR-1:0] raster_start;
  w_t            raster_tri;
  logic          frame_end_req;
  logic          frame_done;
  logic [CW-1:0] tri_count;

  logic [NR-1:0] force_busy;
  logic [NR-1:0] auto_busy;
  logic [NR-1:0] start_seen;
  int            busy_cnt [NR];

  int  n_cmp;
  int  n_err;
  int  exp_cnt;
  sb_t sb_q [$];
  vec_t vecs [9];

  texel_dispatcher #(
    .NUM_RASTER (NR),
    .TEXEL_W    (TW),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .texel_buffer  (texel_buffer),
    .texel_ready   (texel_ready),
    .texel_read    (texel_read),
    .raster_busy   (raster_busy),
    .raster_start  (raster_start),
    .raster_tri    (raster_tri),
    .frame_end_req (frame_end_req),
    .frame_done    (frame_done),
    .tri_count     (tri_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign raster_busy = force_busy | auto_busy;

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Rasterizer model: busy rises the cycle after a start pulse.
  initial begin
    auto_busy  = '0;
    start_seen = '0;
    for (int u = 0; u < NR; u++) busy_cnt[u] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < NR; u++) begin
        if (busy_cnt[u] > 0) busy_cnt[u]--;
        if (start_seen[u]) busy_cnt[u] = BUSY_DUR;
        auto_busy[u] = (busy_cnt[u] != 0);
      end
      start_seen = raster_start;
    end
  end

  // Scoreboard monitor: every start pulse must be one-hot and match the queue.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (raster_start != '0) begin
        chk("start_onehot", w_t'(raster_start & (raster_start - 1'b1)), w_t'(0));
        if (sb_q.size() == 0) begin
          chk("unexpected_start", w_t'(raster_start), w_t'(0));
        end else begin
          e = sb_q.pop_front();
          chk("sb_start", w_t'(raster_start), w_t'(e.start));
          chk("sb_tri", raster_tri, e.tri_w);
        end
      end
    end
  end

  // Offer one triangle, expect its start pulse one cycle later.
  task automatic send(input logic [NR-1:0] frc, input w_t data,
                      input logic [NR-1:0] exp_start, input bit with_req,
                      input int settle);
    int  lat;
    bit  got;
    sb_t e;
    lat = 0;
    got = 1'b0;
    @(posedge clk);
    #1;
    force_busy    = frc;
    texel_buffer  = data;
    texel_ready   = 1'b1;
    frame_end_req = with_req;
    e.start = exp_start;
    e.tri_w = data;
    sb_q.push_back(e);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      frame_end_req = 1'b0;
      if (texel_read) begin
        lat = c + 1;
        got = 1'b1;
        break;
      end
    end
    chk("read_latency", w_t'(lat), w_t'(1));
    chk("start_at_read", w_t'(raster_start), w_t'(exp_start));
    texel_ready = 1'b0;
    force_busy  = '0;
    if (got) exp_cnt++;
    if (settle > 0) begin
      repeat (settle) @(posedge clk);
      #1;
      chk("tri_count", w_t'(tri_count), w_t'(exp_cnt));
    end
  endtask

  // Optionally request a frame end, then wait (bounded) for frame_done.
  task automatic close_frame(input bit do_req);
    bit got;
    got = 1'b0;
    if (do_req) begin
      @(posedge clk);
      #1;
      frame_end_req = 1'b1;
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      frame_end_req = 1'b0;
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("frame_done_seen", w_t'(got), w_t'(1));
    chk("count_after_done", w_t'(tri_count), w_t'(0));
    @(posedge clk);
    #1;
    chk("done_one_cycle", w_t'(frame_done), w_t'(0));
    exp_cnt = 0;
  endtask

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt;
    int dn_cnt;
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 0;

    vecs[0] = '{frc: 4'b0000, data: {21{8'h01}}, exp_start: 4'b0001};
    vecs[1] = '{frc: 4'b0000, data: {21{8'h12}}, exp_start: 4'b0010};
    vecs[2] = '{frc: 4'b0000, data: {21{8'h23}}, exp_start: 4'b0100};
    vecs[3] = '{frc: 4'b0000, data: {21{8'h34}}, exp_start: 4'b1000};
    vecs[4] = '{frc: 4'b1011, data: {21{8'h45}}, exp_start: 4'b0100};
    vecs[5] = '{frc: 4'b0110, data: {21{8'h56}}, exp_start: 4'b1000};
    vecs[6] = '{frc: 4'b0001, data: {21{8'h67}}, exp_start: 4'b0010};
    vecs[7] = '{frc: 4'b1100, data: {21{8'h78}}, exp_start: 4'b0001};
    vecs[8] = '{frc: 4'b0000, data: {21{8'hA5}}, exp_start: 4'b0010};

    n_rst         = 1'b0;
    texel_buffer  = '0;
    texel_ready   = 1'b0;
    frame_end_req = 1'b0;
    force_busy    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("rst_read", w_t'(texel_read), w_t'(0));
    chk("rst_start", w_t'(raster_start), w_t'(0));
    chk("rst_tri", raster_tri, '1);
    chk("rst_done", w_t'(frame_done), w_t'(0));
    chk("rst_count", w_t'(tri_count), w_t'(0));

    // Reset asserted while the issue cycle is in progress.
    @(posedge clk);
    #1;
    texel_buffer = {21{8'h3C}};
    texel_ready  = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_reset_read", w_t'(texel_read), w_t'(1));
    n_rst = 1'b0;
    #1;
    chk("midrst_read", w_t'(texel_read), w_t'(0));
    chk("midrst_start", w_t'(raster_start), w_t'(0));
    chk("midrst_tri", raster_tri, '1);
    chk("midrst_count", w_t'(tri_count), w_t'(0));
    chk("midrst_done", w_t'(frame_done), w_t'(0));
    texel_ready = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Table: round-robin order under various busy masks.
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].frc, vecs[i].data, vecs[i].exp_start, 1'b0, 4);
    end
    chk("tri_held", raster_tri, {21{8'hA5}});

    // All units busy: triangle held, no read, until unit 2 frees.
    @(posedge clk);
    #1;
    force_busy   = 4'b1111;
    texel_buffer = {21{8'h9E}};
    texel_ready  = 1'b1;
    rd_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (texel_read) rd_cnt++;
    end
    chk("stall_no_read", w_t'(rd_cnt), w_t'(0));
    texel_ready = 1'b0;
    send(4'b1011, {21{8'h9E}}, 4'b0100, 1'b0, 4);

    close_frame(1'b1);

    // Three triangles, then a frame end while units 0 and 1 stay busy.
    send(4'b0000, {21{8'hC1}}, 4'b1000, 1'b0, 4);
    send(4'b0000, {21{8'hC2}}, 4'b0001, 1'b0, 4);
    send(4'b0000, {21{8'hC3}}, 4'b0010, 1'b0, 4);
    @(posedge clk);
    #1;
    force_busy    = 4'b0011;
    frame_end_req = 1'b1;
    @(posedge clk);
    #1;
    frame_end_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    frame_end_req = 1'b1;
    @(posedge clk);
    #1;
    frame_end_req = 1'b0;
    chk("drain_wait_done", w_t'(frame_done), w_t'(0));
    chk("drain_count3", w_t'(tri_count), w_t'(3));
    force_busy = '0;
    @(posedge clk);
    #1;
    chk("drain_done_pulse", w_t'(frame_done), w_t'(1));
    chk("drain_count0", w_t'(tri_count), w_t'(0));
    exp_cnt = 0;
    dn_cnt  = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (frame_done) dn_cnt++;
    end
    chk("req_in_drain_ignored", w_t'(dn_cnt), w_t'(0));

    // Empty frame: done two edges after the edge that samples the request.
    frame_end_req = 1'b1;
    @(posedge clk);
    #1;
    frame_end_req = 1'b0;
    chk("empty_done_e0", w_t'(frame_done), w_t'(0));
    @(posedge clk);
    #1;
    chk("empty_done_e1", w_t'(frame_done), w_t'(0));
    @(posedge clk);
    #1;
    chk("empty_done_e2", w_t'(frame_done), w_t'(1));
    @(posedge clk);
    send(4'b0000, {21{8'hD4}}, 4'b0100, 1'b0, 4);

    // Frame end on the same edge as the issue: issue completes, then drain.
    send(4'b0000, {21{8'hE5}}, 4'b1000, 1'b1, 0);
    close_frame(1'b0);

    // Triangle offered after the frame end: block stalls, then drains.
    @(posedge clk);
    #1;
    frame_end_req = 1'b1;
    @(posedge clk);
    #1;
    frame_end_req = 1'b0;
    texel_buffer  = {21{8'hF6}};
    texel_ready   = 1'b1;
    rd_cnt = 0;
    dn_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (texel_read) rd_cnt++;
      if (frame_done) dn_cnt++;
    end
    chk("endpend_no_read", w_t'(rd_cnt), w_t'(0));
    chk("endpend_no_done", w_t'(dn_cnt), w_t'(0));
    texel_ready = 1'b0;
    close_frame(1'b0);
    send(4'b0000, {21{8'hF6}}, 4'b0001, 1'b0, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", w_t'(sb_q.size()), w_t'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/texel_dispatcher.md
Name: texel_dispatcher

Overview:
Sits between the texel assembler and a bank of NUM_RASTER rasterizer units. It takes each assembled 168-bit triangle (vertices + colour), consumes it with a texel_read pulse, and starts one idle rasterizer chosen round-robin. It counts the triangles in each frame and, on a frame-end request, drains all units before signalling frame_done to the host side.

Parameters:
NUM_RASTER, 4, number of rasterizer units (2..8)
TEXEL_W, 168, width of an assembled triangle word
CNT_W, 16, width of the per-frame triangle counter (wraps)

Ports:
clk  in  1  system clock, all logic rising-edge
n_rst  in  1  asynchronous active-low reset
texel_buffer  in  TEXEL_W  assembled triangle, stable while texel_ready=1
texel_ready  in  1  assembler holds a complete triangle
texel_read  out  1  one-cycle pulse: triangle consumed
raster_busy  in  NUM_RASTER  per-unit busy, rises the cycle after its start pulse
raster_start  out  NUM_RASTER  one-hot, one-cycle start pulse
raster_tri  out  TEXEL_W  registered triangle for the started unit, held until next issue
frame_end_req  in  1  one-cycle pulse: host closes the current frame
frame_done  out  1  one-cycle pulse: frame fully rasterized
tri_count  out  CNT_W  triangles issued in the current frame

Behaviour:
- Reset values (async on n_rst=0, any state, mid-operation included): state=IDLE, texel_read=0, raster_start=0, raster_tri=all-ones, frame_done=0, tri_count=0, rr_ptr=0, pending=0, end_pend=0. All outputs are registered.
- avail = ~raster_busy & ~pending. pending is set for exactly one cycle on the unit just started; it covers the cycle before that unit's busy rises.
- Round-robin: grant = the first set bit of avail at or above rr_ptr, wrapping modulo NUM_RASTER. After an issue, rr_ptr = grant+1 (mod NUM_RASTER).
- States: IDLE, ISSUE, DRAIN.
- IDLE: if texel_ready && |avail && !end_pend, go to ISSUE. On that edge: raster_tri <= texel_buffer and grant is latched. If end_pend && !texel_ready, go to DRAIN. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): texel_read=1 and raster_start[grant]=1. On exit, tri_count increments (wrapping at 2^CNT_W), pending[grant] is set for one cycle, and the state returns to IDLE. The assembler deasserts texel_ready on the following cycle, so a triangle is never issued twice.
- Throughput: at most one triangle every 2 cycles. Latency from texel_ready rising (with a unit available) to the start pulse is 1 cycle.
- frame_end_req sets end_pend in any state. While end_pend=1, no new issue begins.
- DRAIN: wait until raster_busy==0 and pending==0. Then frame_done=1 for one cycle, tri_count=0, end_pend=0, and the state returns to IDLE.
- Boundary cases:
  - All units busy with texel_ready=1: stay in IDLE. texel_read stays 0 and the triangle is held.
  - frame_end_req in the same cycle as the IDLE->ISSUE transition: the issue completes, then DRAIN follows.
  - frame_end_req while already in DRAIN: no effect.
  - Empty frame (tri_count=0): frame_done is still pulsed, 2 cycles after the request.
  - texel_ready=1 while end_pend=1: that triangle belongs to the next frame. DRAIN is entered only when texel_ready=0; while texel_ready stays 1 the block remains in IDLE, blocked. The host must not close a frame with a triangle outstanding; the bench checks that the block stalls rather than corrupts.
  - A unit's raster_busy toggling mid-cycle never causes a second start: raster_start is one-hot or zero, always.

Decomposition:
- Shared package gpu_pkg:
  - TEXEL_W=168 and the texel word type.
  - Dispatcher state enum {IDLE, ISSUE, DRAIN}.
  - FRAME_START=0 and FRAME_END=1 word constants, shared with the assembler.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr[log2N]; outputs grant one-hot and gnt_valid. Purely combinational.
- The FSM, counter and registers stay in texel_dispatcher.

Test Plan:
1. Reset mid-ISSUE: assert n_rst=0 during texel_read=1 -> next sample shows all outputs at reset values, tri_count=0, raster_tri=all-ones.
2. Four triangles, all units idle, NUM_RASTER=4 -> raster_start sequence 0001, 0010, 0100, 1000, each 1 cycle after texel_ready; texel_read pulses 4 times; tri_count=4.
3. raster_busy=1011 with rr_ptr=0 and a triangle ready -> raster_start=0100; rr_ptr becomes 3. Then raster_busy=1111 -> no start and texel_read stays 0 until a unit frees.
4. Triangle with texel_buffer=168'hA5... -> raster_tri equals it exactly while raster_start is high, and holds that value afterwards.
5. Three triangles issued, then frame_end_req while units 0 and 1 are busy -> frame_done pulses 1 cycle after raster_busy reaches 0; tri_count reads 3 before the pulse and 0 after.
6. frame_end_req with no triangles issued -> frame_done pulses 2 cycles later. Then a new triangle -> it starts on unit rr_ptr and tri_count=1.
